// File: rtl/instr_mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// instr_mem_rr_arbiter
//
// Round-robin arbiter that lets three single-cycle CPUs share one instruction
// memory. Only one access is in flight at a time. The grant is held for the
// whole access, and the read data is steered back to the core that won.
//
// Access sequence: IDLE -> ISSUE -> WAIT* -> RESP -> IDLE.
// There are MEM_LATENCY-1 WAIT cycles, so one fetch takes MEM_LATENCY+2 cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   req[2:0]   fetch request per CPU
//   addr_0..2  fetch address per CPU
//   gnt[2:0]   one-hot grant (or 0), held ISSUE..RESP
//   mem_en     one-cycle read strobe (high during ISSUE)
//   mem_addr   registered address of the granted CPU
//   mem_rdata  memory read data, valid MEM_LATENCY cycles after mem_en
//   rsp_valid  one-hot response pulse for the granted CPU (RESP cycle)
//   rsp_data   mem_rdata passed through during RESP, 0 otherwise
//
// state | meaning
// IDLE  | no access; arbitrate among pending requests
// ISSUE | mem_en high; the read strobe goes to memory
// WAIT  | waiting for the memory latency; cnt counts down
// RESP  | mem_rdata valid; pulse rsp_valid to the winner
// -----------------------------------------------------------------------------
module instr_mem_rr_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  output logic [2:0]        gnt,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("instr_mem_rr_arbiter: MEM_LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [1:0]        last_q,     last_d;
  logic [2:0]        gnt_q,      gnt_d;
  logic              mem_en_q,   mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [1:0]        win;
  logic              win_vld;
  logic [ADDR_W-1:0] win_addr;

  // Search order is last+1, last+2, last (mod 3). The CPU served most
  // recently therefore has the lowest priority in the next round.
  always_comb begin
    win_vld = |req;
    win     = 2'd0;
    case (last_q)
      2'd0: begin
        if (req[1])      win = 2'd1;
        else if (req[2]) win = 2'd2;
        else             win = 2'd0;
      end
      2'd1: begin
        if (req[2])      win = 2'd2;
        else if (req[0]) win = 2'd0;
        else             win = 2'd1;
      end
      default: begin
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
      end
    endcase
  end

  always_comb begin
    win_addr = addr_0;
    case (win)
      2'd1:    win_addr = addr_1;
      2'd2:    win_addr = addr_2;
      default: win_addr = addr_0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;

    case (state_q)
      IDLE: begin
        gnt_d = 3'b000;
        if (win_vld) begin
          gnt_d      = 3'b001 << win;
          mem_en_d   = 1'b1;
          mem_addr_d = win_addr;
          last_d     = win;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = (MEM_LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        // Stop at 1 rather than 0 so that RESP lines up with the data
        // becoming valid. This also means the counter never wraps.
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        gnt_d   = 3'b000;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 3'b000;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 2'd2;
      gnt_q      <= 3'b000;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign gnt       = gnt_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = (state_q == RESP) ? gnt_q : 3'b000;
  assign rsp_data  = (state_q == RESP) ? mem_rdata : '0;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));

endmodule

// File: tb/tb_instr_mem_rr_arbiter.sv
module tb_instr_mem_rr_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [31:0] addr_0 = '0, addr_1 = '0, addr_2 = '0;
  logic [2:0]  gnt;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  rsp_valid;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  instr_mem_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .addr_0(addr_0), .addr_1(addr_1), .addr_2(addr_2),
    .gnt(gnt), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    int idx;
    logic [1:0] p;
    p = last;
    for (int k = 3; k >= 1; k--) begin
      idx = (int'(last) + k) % 3;
      if (r[idx]) p = 2'(idx);
    end
    return p;
  endfunction

  // ---------------- memory model: data appears LAT cycles after mem_en
  logic        hist_en[LAT];
  logic [31:0] hist_addr[LAT];
  always @(negedge clk) begin
    for (int k = LAT - 1; k > 0; k--) begin
      hist_en[k]   = hist_en[k-1];
      hist_addr[k] = hist_addr[k-1];
    end
    hist_en[0]   = mem_en;
    hist_addr[0] = mem_addr;
  end
  always @(posedge clk) begin
    #1;
    if (hist_en[LAT-1] === 1'b1) mem_rdata = memf(hist_addr[LAT-1]);
    else                         mem_rdata = $urandom;
  end

  // ---------------- reference model + scoreboard
  typedef struct packed {
    logic [1:0]  cpu;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic        m_busy, m_en, m_resp;
  logic [2:0]  m_gnt;
  logic [31:0] m_addr;
  logic [1:0]  m_last;
  int          m_age;
  int          pend[3];

  always @(posedge clk) begin
    logic [1:0] w;
    if (!rst_n) begin
      m_busy = 0; m_en = 0; m_resp = 0; m_gnt = 0; m_addr = 0; m_last = 2'd2; m_age = 0;
      sb.delete();
      for (int i = 0; i < 3; i++) pend[i] = 0;
    end else if (!m_busy) begin
      m_en = 0; m_resp = 0; m_gnt = 0;
      if (req != 3'b000) begin
        w = rr_pick(req, m_last);
        for (int i = 0; i < 3; i++) begin
          if (req[i] && i != int'(w)) pend[i] = pend[i] + 1;
          else                        pend[i] = 0;
        end
        m_gnt  = 3'b001 << w;
        m_en   = 1;
        m_addr = (w == 2'd0) ? addr_0 : (w == 2'd1) ? addr_1 : addr_2;
        m_last = w;
        m_busy = 1;
        m_age  = 0;
        sb.push_back('{cpu: w, data: memf(m_addr)});
      end
    end else if (m_resp) begin
      m_busy = 0; m_resp = 0; m_gnt = 0; m_en = 0;
    end else begin
      m_en   = 0;
      m_age  = m_age + 1;
      m_resp = (m_age == LAT);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [2:0] exp_rv;
    if (mon_en) begin
      checks++;
      if (gnt !== m_gnt) begin
        errors++; $display("FAIL mon_gnt t=%0t got %b exp %b", $time, gnt, m_gnt);
      end
      checks++;
      if (!$onehot0(gnt)) begin
        errors++; $display("FAIL mon_onehot t=%0t got %b exp onehot0", $time, gnt);
      end
      checks++;
      if (mem_en !== m_en) begin
        errors++; $display("FAIL mon_mem_en t=%0t got %b exp %b", $time, mem_en, m_en);
      end
      if (m_en) begin
        checks++;
        if (mem_addr !== m_addr) begin
          errors++; $display("FAIL mon_mem_addr t=%0t got %h exp %h", $time, mem_addr, m_addr);
        end
      end
      exp_rv = m_resp ? m_gnt : 3'b000;
      checks++;
      if (rsp_valid !== exp_rv) begin
        errors++; $display("FAIL mon_rsp_valid t=%0t got %b exp %b", $time, rsp_valid, exp_rv);
      end
      if (m_resp) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL mon_sb_empty t=%0t got empty exp entry", $time);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== (3'b001 << e.cpu) || rsp_data !== e.data) begin
            errors++;
            $display("FAIL mon_rsp_data t=%0t got %b/%h exp %b/%h", $time,
                     rsp_valid, rsp_data, 3'b001 << e.cpu, e.data);
          end
        end
      end else begin
        checks++;
        if (rsp_data !== 32'h0) begin
          errors++; $display("FAIL mon_rsp_zero t=%0t got %h exp 0", $time, rsp_data);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pend[i] > 2) begin
          errors++; $display("FAIL mon_starve cpu%0d got %0d lost rounds exp <=2", i, pend[i]);
        end
      end
    end
  end

  // ---------------- stimulus helpers (no checking inside)
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_access(input logic [2:0] r, output logic [2:0] g);
    g = 3'b000;
    @(negedge clk);
    req = r;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        g = gnt;
        break;
      end
    end
    req = 3'b000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt === 3'b000) break;
    end
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || mem_en !== 1'b0 || mem_addr !== 32'h0 ||
        rsp_valid !== 3'b000 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b en=%b addr=%h rv=%b rd=%h exp all zero",
               gnt, mem_en, mem_addr, rsp_valid, rsp_data);
    end
    mon_en = 1'b1;
    rst_n  = 1'b1;
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    req = 3'b001; addr_0 = 32'h10;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b001 || mem_en !== 1'b1 || mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL single_issue got gnt=%b en=%b addr=%h exp 001/1/00000010", gnt, mem_en, mem_addr);
    end
    req = 3'b000;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b001 || mem_en !== 1'b0 || rsp_valid !== 3'b000) begin
      errors++;
      $display("FAIL single_wait got gnt=%b en=%b rv=%b exp 001/0/000", gnt, mem_en, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 3'b001 || rsp_data !== memf(32'h10)) begin
      errors++;
      $display("FAIL single_resp got rv=%b rd=%h exp 001/%h", rsp_valid, rsp_data, memf(32'h10));
    end
    @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || rsp_valid !== 3'b000) begin
      errors++; $display("FAIL single_release got gnt=%b rv=%b exp 000/000", gnt, rsp_valid);
    end
  endtask

  task automatic test_rr_all();
    logic [2:0] g[4];
    int cyc[4];
    int n = 0;
    logic [2:0] exp_g[4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    do_reset();
    addr_0 = 32'h100; addr_1 = 32'h104; addr_2 = 32'h108;
    req = 3'b111;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        g[n] = gnt; cyc[n] = c; n++;
      end
    end
    req = 3'b000;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL rr_all_count got %0d grants exp 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (g[k] !== exp_g[k]) begin
          errors++; $display("FAIL rr_all_gnt%0d got %b exp %b", k, g[k], exp_g[k]);
        end
        if (k > 0) begin
          checks++;
          if (cyc[k] - cyc[k-1] != LAT + 2) begin
            errors++; $display("FAIL rr_all_spacing%0d got %0d exp %0d", k, cyc[k] - cyc[k-1], LAT + 2);
          end
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt === 3'b000) break;
    end
  endtask

  task automatic test_rotation();
    logic [2:0] g;
    run_access(3'b010, g);
    checks++;
    if (g !== 3'b010) begin errors++; $display("FAIL rot_cpu1 got %b exp 010", g); end
    run_access(3'b011, g);
    checks++;
    if (g !== 3'b001) begin errors++; $display("FAIL rot_after1 got %b exp 001", g); end
    run_access(3'b011, g);
    checks++;
    if (g !== 3'b010) begin errors++; $display("FAIL rot_after0 got %b exp 010", g); end
  endtask

  task automatic test_drop_req();
    logic seen = 1'b0;
    @(negedge clk);
    req = 3'b100; addr_2 = 32'h200;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || gnt !== 3'b100 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL drop_issue got gnt=%b addr=%h exp 100/00000200", gnt, mem_addr);
    end
    @(negedge clk);
    req = 3'b000; addr_2 = 32'h300;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 3'b100 || mem_addr !== 32'h200 || rsp_data !== memf(32'h200)) begin
      errors++;
      $display("FAIL drop_resp got rv=%b addr=%h rd=%h exp 100/00000200/%h",
               rsp_valid, mem_addr, rsp_data, memf(32'h200));
    end
    @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || rsp_valid !== 3'b000 || mem_en !== 1'b0) begin
      errors++; $display("FAIL drop_idle got gnt=%b rv=%b en=%b exp 000/000/0", gnt, rsp_valid, mem_en);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] g;
    logic seen = 1'b0;
    @(negedge clk);
    req = 3'b001; addr_0 = 32'h40;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin seen = 1'b1; break; end
    end
    req = 3'b000;
    @(negedge clk);
    checks++;
    if (!seen || gnt !== 3'b001 || mem_en !== 1'b0) begin
      errors++; $display("FAIL rstmid_wait got gnt=%b en=%b exp 001/0", gnt, mem_en);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || rsp_valid !== 3'b000 || mem_en !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs got gnt=%b rv=%b en=%b addr=%h exp zeros", gnt, rsp_valid, mem_en, mem_addr);
    end
    rst_n = 1'b1;
    run_access(3'b011, g);
    checks++;
    if (g !== 3'b001) begin errors++; $display("FAIL rstmid_prio got %b exp 001", g); end
    run_access(3'b010, g);
    checks++;
    if (g !== 3'b010) begin errors++; $display("FAIL rstmid_cpu1 got %b exp 010", g); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      req    = 3'($urandom_range(0, 7));
      addr_0 = $urandom; addr_1 = $urandom; addr_2 = $urandom;
    end
    @(negedge clk);
    req = 3'b000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt === 3'b000) break;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL random_drain got %0d pending exp 0", sb.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_rr_all();
    test_rotation();
    test_drop_req();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
